// File: rtl/tx_serial_uart.sv
// tx_serial_uart
//   Asynchronous serial transmitter. Each accepted byte goes out as one
//   frame: a start bit (0), eight data bits LSB first, an optional parity
//   bit, and one stop bit (1). Every bit is held for CLKS_POR_BIT clock
//   cycles. The end of the frame is flagged by a one-cycle pulse on pronto.
//
// Parameters
//   CLKS_POR_BIT  clock cycles per serial bit (>= 2)
//   PARIDADE      0 = no parity (10-bit frame), 1 = even, 2 = odd (11-bit frame)
//
// Ports
//   clock         system clock, rising edge
//   reset         synchronous, active-high; aborts any frame in progress
//   partida       start request, only honoured while idle (INICIAL)
//   dados_ascii   byte to send, captured on the edge that accepts partida
//   saida_serial  serial line, idles at 1
//   pronto        one-cycle pulse in the FINAL state
//   ocupado       high whenever the FSM is outside INICIAL
//   db_estado     current FSM state code (debug)
module tx_serial_uart #(
  parameter int CLKS_POR_BIT = 434,
  parameter int PARIDADE     = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados_ascii,
  output logic       saida_serial,
  output logic       pronto,
  output logic       ocupado,
  output logic [1:0] db_estado
);

  localparam int N_BITS = (PARIDADE == 0) ? 10 : 11;
  localparam int TICK_W = $clog2(CLKS_POR_BIT);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLKS_POR_BIT - 1);
  localparam logic [3:0]        BIT_MAX  = 4'(N_BITS - 1);

  typedef enum logic [1:0] {
    INICIAL     = 2'd0,
    PREPARACAO  = 2'd1,
    TRANSMISSAO = 2'd2,
    FINAL       = 2'd3
  } estado_t;

  estado_t             estado;
  estado_t             proximo;
  logic [TICK_W-1:0]   tick_cnt;
  logic [3:0]          bit_cnt;
  logic [7:0]          dados_lat;
  logic [N_BITS-1:0]   quadro;
  logic                fim_bit;

  // Parity is taken from the latched byte only, so later changes on
  // dados_ascii cannot leak into a frame already accepted.
  function automatic logic bit_paridade(input logic [7:0] d);
    return (PARIDADE == 2) ? ~(^d) : (^d);
  endfunction

  // Frame image, transmitted from bit 0 upwards: start, data LSB first,
  // optional parity, stop. Built 11 bits wide and trimmed to N_BITS.
  function automatic logic [N_BITS-1:0] monta_quadro(input logic [7:0] d);
    logic [10:0] completo;
    if (PARIDADE == 0) completo = {1'b1, 1'b1, d, 1'b0};
    else               completo = {1'b1, bit_paridade(d), d, 1'b0};
    return N_BITS'(completo);
  endfunction

  always_comb begin
    fim_bit = (tick_cnt == TICK_MAX);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  // Next-state logic
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:     if (partida) proximo = PREPARACAO;
      PREPARACAO:  proximo = TRANSMISSAO;
      TRANSMISSAO: if (fim_bit && (bit_cnt == BIT_MAX)) proximo = FINAL;
      FINAL:       proximo = INICIAL;
      default:     proximo = INICIAL;
    endcase
  end

  // Bit timing counters
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (estado)
        PREPARACAO: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
        TRANSMISSAO: begin
          if (fim_bit) begin
            tick_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        default: begin
          tick_cnt <= tick_cnt;
          bit_cnt  <= bit_cnt;
        end
      endcase
    end
  end

  // Data path: byte latch and frame shift register. No reset needed here,
  // the line is forced to 1 outside TRANSMISSAO.
  always_ff @(posedge clock) begin
    if ((estado == INICIAL) && partida) dados_lat <= dados_ascii;
    if (estado == PREPARACAO) begin
      quadro <= monta_quadro(dados_lat);
    end else if ((estado == TRANSMISSAO) && fim_bit) begin
      quadro <= {1'b1, quadro[N_BITS-1:1]};
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    saida_serial = 1'b1;
    pronto       = 1'b0;
    ocupado      = (estado != INICIAL);
    db_estado    = estado;
    case (estado)
      TRANSMISSAO: saida_serial = quadro[0];
      FINAL:       pronto       = 1'b1;
      default:     saida_serial = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_tx_serial_uart.sv
// Testbench for tx_serial_uart. Three instances with CLKS_POR_BIT=4 cover
// no parity, even parity and odd parity. A reference model on the rising
// edge decides which requests are accepted and queues the expected frame;
// a monitor on the falling edge compares every cycle of every instance
// against the queued frame and retires the entry on its pronto cycle.
module tb_tx_serial_uart;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       partida [3];
  logic [7:0] dados   [3];
  logic       saida   [3];
  logic       pronto  [3];
  logic       ocupado [3];
  logic [1:0] estado  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tx_serial_uart #(
      .CLKS_POR_BIT(C),
      .PARIDADE    (g)
    ) u_dut (
      .clock       (clk),
      .reset       (rst),
      .partida     (partida[g]),
      .dados_ascii (dados[g]),
      .saida_serial(saida[g]),
      .pronto      (pronto[g]),
      .ocupado     (ocupado[g]),
      .db_estado   (estado[g])
    );
  end

  typedef struct {
    int         d;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   next_acc [3] = '{0, 0, 0};
  int   accepted [3] = '{0, 0, 0};
  bit   mon_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  function automatic int nbits(input int d);
    return (d == 0) ? 10 : 11;
  endfunction

  // Level of frame bit idx for a byte, from the frame definition.
  function automatic logic frame_bit(input int d, input logic [7:0] data, input int idx);
    int ones;
    ones = $countones(data);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[idx-1];
    if ((d != 0) && (idx == 9)) return (d == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  // Reference model: an idle transmitter accepts partida; the frame starts
  // two edges later, pronto follows N_BITS*C cycles after the start, and
  // the next request can be taken on the edge after the idle cycle.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      sb.delete();
      for (int d = 0; d < 3; d++) next_acc[d] = cyc + 1;
      mon_en = 1'b1;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (partida[d] && (cyc >= next_acc[d])) begin
          e.d     = d;
          e.data  = dados[d];
          e.start = cyc + 1;
          sb.push_back(e);
          next_acc[d] = cyc + 3 + nbits(d) * C;
          accepted[d] = accepted[d] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, every instance.
  always @(negedge clk) begin
    int idx;
    int s;
    int el, ep, eo, es;
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if ((idx < 0) && (sb[i].d == d)) idx = i;
        end
        el = 1; ep = 0; eo = 0; es = 0;
        if (idx >= 0) begin
          s = sb[idx].start;
          if (cyc == s - 1) begin
            es = 1; eo = 1;
          end else if ((cyc >= s) && (cyc < s + nbits(d) * C)) begin
            es = 2; eo = 1;
            el = int'(frame_bit(d, sb[idx].data, (cyc - s) / C));
          end else if (cyc == s + nbits(d) * C) begin
            es = 3; eo = 1; ep = 1;
          end
        end
        chk("saida_serial", d, int'(saida[d]), el);
        chk("pronto", d, int'(pronto[d]), ep);
        chk("ocupado", d, int'(ocupado[d]), eo);
        chk("db_estado", d, int'(estado[d]), es);
        if (ep == 1) sb.delete(idx);
      end
    end
  end

  task automatic wait_idle(input int d);
    for (int i = 0; (i < 500) && (cyc + 1 < next_acc[d]); i++) @(negedge clk);
  endtask

  task automatic send(input int d, input logic [7:0] b);
    wait_idle(d);
    partida[d] = 1'b1;
    dados[d]   = b;
    @(negedge clk);
    partida[d] = 1'b0;
  endtask

  task automatic wait_accept(input int d, input int target);
    for (int i = 0; (i < 500) && (accepted[d] < target); i++) @(negedge clk);
  endtask

  initial begin
    int base;
    for (int d = 0; d < 3; d++) begin
      partida[d] = 1'b0;
      dados[d]   = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frames: 0x41 without parity, 0x07 with even and odd parity
    partida[0] = 1'b1; dados[0] = 8'h41;
    partida[1] = 1'b1; dados[1] = 8'h07;
    partida[2] = 1'b1; dados[2] = 8'h07;
    @(negedge clk);
    for (int d = 0; d < 3; d++) partida[d] = 1'b0;
    for (int d = 0; d < 3; d++) wait_idle(d);
    repeat (5) @(negedge clk);

    // Request while busy is ignored
    send(0, 8'h41);
    repeat (9) @(negedge clk);
    partida[0] = 1'b1; dados[0] = 8'h55;
    @(negedge clk);
    partida[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);

    // Back-to-back frames with partida held high
    for (int d = 0; d < 2; d++) begin
      base = accepted[d];
      partida[d] = 1'b1; dados[d] = 8'h30;
      wait_accept(d, base + 1);
      dados[d] = 8'h31;
      wait_accept(d, base + 2);
      partida[d] = 1'b0;
      wait_idle(d);
      repeat (5) @(negedge clk);
    end

    // Reset during data bit 3, then a clean frame
    send(0, 8'h41);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(0, 8'h41);
    wait_idle(0);
    repeat (5) @(negedge clk);

    // Data changing every cycle after the accepting edge
    for (int d = 0; d < 3; d++) begin
      partida[d] = 1'b1;
      dados[d]   = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) partida[d] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      for (int d = 0; d < 3; d++) dados[d] = 8'($urandom_range(0, 255));
      @(negedge clk);
    end

    // Random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      for (int d = 0; d < 3; d++) begin
        partida[d] = ($urandom_range(0, 19) == 0);
        dados[d]   = 8'($urandom_range(0, 255));
      end
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) partida[d] = 1'b0;
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_serial_uart.md
Name: tx_serial_uart

Overview:
- Asynchronous serial transmitter. Sits directly downstream of the measurement transmission control unit.
- Accepts one ASCII byte per `partida` pulse and shifts out a start bit, 8 data bits (LSB first), an optional parity bit and one stop bit on `saida_serial`.
- Signals completion with a one-cycle `pronto`, which the control unit consumes as `pronto_transmissao`. The control unit's `tx_transmite` drives `partida`.

Parameters:
- CLKS_POR_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range >= 2.
- PARIDADE, 0, 0 = none (10-bit frame), 1 = even, 2 = odd (11-bit frame).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- partida  input  1  start request; sampled only in INICIAL.
- dados_ascii  input  8  byte to send; latched on the edge that samples partida.
- saida_serial  output  1  serial line; idle level 1.
- pronto  output  1  one-cycle pulse at end of frame.
- ocupado  output  1  high while a frame is in progress (any state other than INICIAL).
- db_estado  output  2  current state code, for debug.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: on a rising edge with reset=1 the state becomes INICIAL and all counters clear.
  - Reset wins over every other input, including in the middle of a frame.
  - After reset: saida_serial=1, pronto=0, ocupado=0, db_estado=0.
- States and codes: INICIAL=0, PREPARACAO=1, TRANSMISSAO=2, FINAL=3.
- INICIAL:
  - saida_serial=1.
  - If partida=1 at an edge: latch dados_ascii, go to PREPARACAO. Otherwise stay.
- PREPARACAO (exactly 1 cycle):
  - Load frame shift register: bit0 = start (0), bits 1..8 = data LSB first, then parity bit if PARIDADE != 0, then stop (1).
  - Clear the tick counter and the bit counter. Go to TRANSMISSAO.
  - saida_serial=1 during this cycle.
- TRANSMISSAO:
  - saida_serial = shift register bit 0. The output is decoded from registered state only and has no combinational path from the inputs.
  - Each bit is held for exactly CLKS_POR_BIT cycles.
  - When the tick counter reaches CLKS_POR_BIT-1: shift right (fill with 1), increment the bit counter, clear the tick counter.
  - After the last bit (10 bits, or 11 with parity) go to FINAL.
- FINAL (exactly 1 cycle): pronto=1, saida_serial=1, then go to INICIAL.
- Latency:
  - Start bit begins in the cycle after edge E0+1, where E0 is the edge that sampled partida.
  - TRANSMISSAO lasts N_BITS*CLKS_POR_BIT cycles.
  - pronto is high in the cycle after edge E0+1+N_BITS*CLKS_POR_BIT.
- Parity:
  - Even parity bit = XOR of the latched data bits.
  - Odd parity bit = the inverse of that.
  - Computed from the latched copy, never from the live input.
- Boundary conditions:
  - partida asserted in any state other than INICIAL: ignored. No queueing, no effect on the current frame.
  - dados_ascii changing after the latch edge: no effect on the frame.
  - partida held high continuously: frames repeat back-to-back. The minimum idle gap between one stop bit and the next start bit is 3 cycles at level 1 (FINAL, INICIAL, PREPARACAO).
  - Reset mid-frame: saida_serial returns to 1 the cycle after the reset edge. No pronto is generated for the aborted frame.
- Width rules:
  - Tick counter width = clog2(CLKS_POR_BIT).
  - Bit counter is 4 bits.
  - No overflow is permitted within legal parameter values.

Test Plan:
- CLKS_POR_BIT=4, PARIDADE=0, send 0x41 -> saida_serial holds each level for 4 cycles in the order 0,1,0,0,0,0,0,1,0,1; pronto is a single-cycle pulse 41 edges after the partida edge; ocupado is high for 42 cycles.
- CLKS_POR_BIT=4, PARIDADE=1, send 0x07 -> data 1,1,1,0,0,0,0,0, parity bit 1, stop 1; pronto 45 edges after partida. Repeat with PARIDADE=2 -> parity bit 0.
- Busy rejection: pulse partida with 0x55 at cycle 10 of a frame carrying 0x41 -> the 0x41 frame completes unchanged; exactly one pronto pulse; the line then stays at 1.
- Back-to-back: hold partida=1, send 0x30 then 0x31 -> two correct frames; gap between the stop-bit end and the next start bit is exactly 3 cycles at 1; two pronto pulses.
- Reset mid-frame: assert reset during data bit 3 -> next cycle saida_serial=1, db_estado=0, ocupado=0, no pronto; a following send of 0x41 is transmitted correctly.
- Data hold: change dados_ascii every cycle after the partida edge -> the transmitted byte equals the value present on the sampling edge.
